ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and performs operand forwarding from MEM/WB. It runs the single-cycle ALU or a multi-cycle iterative multiplier, resolves branches, and owns the EX/MEM pipeline register. While the multiplier is busy it asserts stall_ex, which holds PC, IF/ID and ID/EX.

Parameters:
MUL_CYCLES, 32, iterations of the shift-add multiplier (one per multiplier bit)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex, branch_ex, reg_dst_ex, alu_src_ex  in  1 each  control from ID/EX
alu_op_ex  in  4  ALU operation
read_data1_ex, read_data2_ex, sign_ext_imm_ex, pc_plus_4_ex  in  32 each  data from ID/EX
rs_ex, rt_ex, rd_ex  in  5 each  register specifiers
reg_write_wb  in  1  WB stage write enable
write_reg_wb  in  5  WB destination
write_data_wb  in  32  WB result
reg_write_mem, mem_to_reg_mem, mem_read_mem, mem_write_mem  out  1 each  EX/MEM control
alu_result_mem, write_data_mem  out  32 each  EX/MEM ALU result and store data
write_reg_mem  out  5  EX/MEM destination
branch_taken_mem  out  1  registered branch decision; drives flush of IF/ID and ID/EX, and PC select
branch_target_mem  out  32  registered branch target
stall_ex  out  1  combinational; 1 = freeze PC, IF/ID, ID/EX

Behaviour:
- ALU op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MUL (low 32 bits of product). Any other code gives result 0.
- Forwarding A (rs) and B (rt):
  - Select alu_result_mem if reg_write_mem, write_reg_mem!=0 and it matches the specifier.
  - Otherwise select write_data_wb under the same rule against WB.
  - Otherwise use the register file value.
  - MEM has priority over WB.
  - Load-use hazards are resolved upstream by the hazard unit; this block does not detect them.
- ALU operand B: sign_ext_imm_ex if alu_src_ex, else forwarded B. Store data is always forwarded B.
- Destination: write_reg = reg_dst_ex ? rd_ex : rt_ex.
- Branch:
  - taken = branch_ex && (forwarded A == forwarded B).
  - target = pc_plus_4_ex + (sign_ext_imm_ex << 2), arithmetic mod 2^32.
  - Both are registered into branch_taken_mem and branch_target_mem.
- Squash: while branch_taken_mem=1, the instruction in EX is wrong-path. Treat it as a bubble: EX/MEM loads all control 0, branch_taken_mem loads 0, and no MUL start occurs.
- Bubble means reg_write, mem_read, mem_write, mem_to_reg and branch_taken all 0. Data fields are don't-care and driven 0.
- Non-MUL latency: 1 cycle. Result appears at EX/MEM on the next clk edge.
- MUL FSM:
  - IDLE:
    - If alu_op_ex==MUL and not squashed: latch forwarded A, forwarded B, write_reg and the four MEM/WB controls.
    - Clear the accumulator, set count=0, stall_ex=1, go to BUSY. EX/MEM loads a bubble.
  - BUSY:
    - stall_ex=1. Each cycle: if the multiplier LSB is 1, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1.
    - count increments. Go to DONE after MUL_CYCLES iterations. EX/MEM loads a bubble each cycle.
  - DONE:
    - stall_ex=0. EX/MEM loads acc[31:0] with the latched controls. Return to IDLE.
  - Total EX occupancy is 34 cycles; the product is visible in EX/MEM 34 edges after MUL entered EX.
- The multiplier uses latched operands only. Changes in WB forwarding sources during BUSY must not affect the result.
- stall_ex is 0 in IDLE, except in the start cycle of a MUL as described.
- branch_ex together with MUL is illegal; the decoder never emits it.
- Reset, asynchronous and at any time including mid-multiply: FSM to IDLE, count=0, acc=0, and all outputs 0. stall_ex drops immediately.

Decomposition:
- Shared package cpu_pkg: ALU op code constants, MUL FSM state encoding (IDLE/BUSY/DONE), bubble control constant.
- Sub-module mul_iter: a 32-bit shift-add multiplier with start/busy/done handshake. ex_stage instantiates it and owns forwarding, the ALU, the branch logic and EX/MEM.

Test Plan:
- Forwarding priority: rs_ex=5; MEM writes r5=0x11; WB writes r5=0x22; ADD with rt value 1 → alu_result_mem=0x12. Repeat with write_reg_mem=0 → result 0x23.
- ALU ops: SUB 3-5 → 0xFFFFFFFE. SLT -1 vs 1 → 1. NOR 0,0 → 0xFFFFFFFF. alu_src=1 with imm=0xFFFFFFFC → ADD 8 gives 4.
- Branch: beq with A=B=7, pc_plus_4=0x100, imm=3 → branch_taken_mem=1, target=0x10C. Next cycle the instruction in EX is squashed (reg_write_mem=0 after the edge).
- MUL 7*6 into rd=9:
  - stall_ex high for exactly 33 consecutive cycles.
  - EX/MEM shows bubbles meanwhile, then alu_result_mem=42, write_reg_mem=9, reg_write_mem=1.
  - Repeat with 0xFFFFFFFF*2 → result 0xFFFFFFFE.
- MUL operand isolation: change write_data_wb every cycle during BUSY → product unchanged.
- Reset mid-MUL at iteration 10: stall_ex=0 and all outputs 0 immediately. After release, a fresh ADD completes in 1 cycle with no stale product.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU op codes, multiplier FSM states and EX/MEM layout.
// Imported by the execute stage, its multiplier and the bench.
package cpu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    localparam mem_ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        mem_ctrl_t   ctrl;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic        branch_taken;
        logic [31:0] branch_target;
    } ex_mem_t;

    // MEM wins over WB; register 0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  spec,
        input logic [31:0] rf_val,
        input logic        mem_we,
        input logic [4:0]  mem_reg,
        input logic [31:0] mem_val,
        input logic        wb_we,
        input logic [4:0]  wb_reg,
        input logic [31:0] wb_val
    );
        if (mem_we && (mem_reg != 5'd0) && (mem_reg == spec))
            return mem_val;
        else if (wb_we && (wb_reg != 5'd0) && (wb_reg == spec))
            return wb_val;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage pipeline bus: ID/EX inputs, WB forwarding source, EX/MEM outputs and stall.
// slave = execute stage, master = surrounding pipeline.
interface ex_stage_if;
    logic        reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex;
    logic        branch_ex, reg_dst_ex, alu_src_ex;
    logic [3:0]  alu_op_ex;
    logic [31:0] read_data1_ex, read_data2_ex, sign_ext_imm_ex, pc_plus_4_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        reg_write_wb;
    logic [4:0]  write_reg_wb;
    logic [31:0] write_data_wb;
    logic        reg_write_mem, mem_to_reg_mem, mem_read_mem, mem_write_mem;
    logic [31:0] alu_result_mem, write_data_mem;
    logic [4:0]  write_reg_mem;
    logic        branch_taken_mem;
    logic [31:0] branch_target_mem;
    logic        stall_ex;

    modport master (
        output reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex,
               branch_ex, reg_dst_ex, alu_src_ex, alu_op_ex,
               read_data1_ex, read_data2_ex, sign_ext_imm_ex, pc_plus_4_ex,
               rs_ex, rt_ex, rd_ex, reg_write_wb, write_reg_wb, write_data_wb,
        input  reg_write_mem, mem_to_reg_mem, mem_read_mem, mem_write_mem,
               alu_result_mem, write_data_mem, write_reg_mem,
               branch_taken_mem, branch_target_mem, stall_ex
    );

    modport slave (
        input  reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex,
               branch_ex, reg_dst_ex, alu_src_ex, alu_op_ex,
               read_data1_ex, read_data2_ex, sign_ext_imm_ex, pc_plus_4_ex,
               rs_ex, rt_ex, rd_ex, reg_write_wb, write_reg_wb, write_data_wb,
        output reg_write_mem, mem_to_reg_mem, mem_read_mem, mem_write_mem,
               alu_result_mem, write_data_mem, write_reg_mem,
               branch_taken_mem, branch_target_mem, stall_ex
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; low 32 product bits.
// start is accepted only in IDLE; busy for MUL_CYCLES cycles, then done for one cycle.
module mul_iter
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    localparam int             CW   = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(MUL_CYCLES - 1);

    mul_state_t    state, state_nxt;
    logic [CW-1:0] count;
    logic [31:0]   acc, mcand, mplier;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MUL_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (count == LAST) state_nxt = MUL_DONE;
            MUL_DONE: state_nxt = MUL_IDLE;
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MUL_BUSY);
        done = (state == MUL_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == MUL_IDLE && start) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
        end else if (state == MUL_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: MEM/WB forwarding, ALU, branch resolve, iterative MUL, EX/MEM register.
// ALU ops land in EX/MEM one edge later; MUL stalls upstream and lands 34 edges after entry.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic    clk,
    input  logic    reset,
    ex_stage_if.slave bus
);
    ex_mem_t     ex_mem_q, ex_mem_d;
    logic        squash;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res, br_target;
    logic [4:0]  write_reg;
    mem_ctrl_t   id_ctrl, mul_ctrl;
    logic [4:0]  mul_wreg;
    logic        mul_go, mul_busy, mul_done;
    logic [31:0] mul_product;

    // A taken branch in EX/MEM means the instruction now in EX is wrong-path.
    assign squash = ex_mem_q.branch_taken;

    assign fwd_a = fwd_sel(bus.rs_ex, bus.read_data1_ex, ex_mem_q.ctrl.reg_write,
                           ex_mem_q.write_reg, ex_mem_q.alu_result,
                           bus.reg_write_wb, bus.write_reg_wb, bus.write_data_wb);
    assign fwd_b = fwd_sel(bus.rt_ex, bus.read_data2_ex, ex_mem_q.ctrl.reg_write,
                           ex_mem_q.write_reg, ex_mem_q.alu_result,
                           bus.reg_write_wb, bus.write_reg_wb, bus.write_data_wb);

    assign alu_b     = bus.alu_src_ex ? bus.sign_ext_imm_ex : fwd_b;
    assign write_reg = bus.reg_dst_ex ? bus.rd_ex : bus.rt_ex;
    assign br_target = bus.pc_plus_4_ex + {bus.sign_ext_imm_ex[29:0], 2'b00};
    assign id_ctrl   = '{reg_write:  bus.reg_write_ex,  mem_to_reg: bus.mem_to_reg_ex,
                         mem_read:   bus.mem_read_ex,   mem_write:  bus.mem_write_ex};

    always_comb begin
        alu_res = '0;
        case (bus.alu_op_ex)
            ALU_AND: alu_res = fwd_a & alu_b;
            ALU_OR:  alu_res = fwd_a | alu_b;
            ALU_ADD: alu_res = fwd_a + alu_b;
            ALU_SUB: alu_res = fwd_a - alu_b;
            ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            ALU_NOR: alu_res = ~(fwd_a | alu_b);
            default: alu_res = '0;
        endcase
    end

    // Gating with reset keeps stall low while reset is held even if ID/EX still shows a MUL.
    assign mul_go = (bus.alu_op_ex == ALU_MUL) && !squash && !reset && !mul_busy && !mul_done;
    assign bus.stall_ex = mul_go || mul_busy;

    mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_go),
        .multiplicand (fwd_a),
        .multiplier   (fwd_b),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_ctrl <= CTRL_BUBBLE;
            mul_wreg <= '0;
        end else if (mul_go) begin
            mul_ctrl <= id_ctrl;
            mul_wreg <= write_reg;
        end
    end

    always_comb begin
        ex_mem_d = '0;
        if (mul_done) begin
            ex_mem_d.ctrl       = mul_ctrl;
            ex_mem_d.alu_result = mul_product;
            ex_mem_d.write_reg  = mul_wreg;
        end else if (!squash && !mul_go && !mul_busy) begin
            ex_mem_d.ctrl          = id_ctrl;
            ex_mem_d.alu_result    = alu_res;
            ex_mem_d.write_data    = fwd_b;
            ex_mem_d.write_reg     = write_reg;
            ex_mem_d.branch_taken  = bus.branch_ex && (fwd_a == fwd_b);
            ex_mem_d.branch_target = br_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_mem_q <= '0;
        else       ex_mem_q <= ex_mem_d;
    end

    assign bus.reg_write_mem     = ex_mem_q.ctrl.reg_write;
    assign bus.mem_to_reg_mem    = ex_mem_q.ctrl.mem_to_reg;
    assign bus.mem_read_mem      = ex_mem_q.ctrl.mem_read;
    assign bus.mem_write_mem     = ex_mem_q.ctrl.mem_write;
    assign bus.alu_result_mem    = ex_mem_q.alu_result;
    assign bus.write_data_mem    = ex_mem_q.write_data;
    assign bus.write_reg_mem     = ex_mem_q.write_reg;
    assign bus.branch_taken_mem  = ex_mem_q.branch_taken;
    assign bus.branch_target_mem = ex_mem_q.branch_target;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases then random instructions against a cycle-level
// reference model of EX/MEM contents.
module tb_ex_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage #(.MUL_CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Expected EX/MEM contents
    logic        m_rw, m_mtr, m_mr, m_mw, m_bt;
    logic [31:0] m_res, m_wd, m_tgt;
    logic [4:0]  m_wreg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        {m_rw, m_mtr, m_mr, m_mw, m_bt} = '0;
        m_res = '0; m_wd = '0; m_tgt = '0; m_wreg = '0;
    endtask

    task automatic cmp_mem(input string tag, input bit with_data);
        chk({tag, ".reg_write"},    32'(bus.reg_write_mem),    32'(m_rw));
        chk({tag, ".mem_to_reg"},   32'(bus.mem_to_reg_mem),   32'(m_mtr));
        chk({tag, ".mem_read"},     32'(bus.mem_read_mem),     32'(m_mr));
        chk({tag, ".mem_write"},    32'(bus.mem_write_mem),    32'(m_mw));
        chk({tag, ".branch_taken"}, 32'(bus.branch_taken_mem), 32'(m_bt));
        chk({tag, ".alu_result"},   bus.alu_result_mem,        m_res);
        chk({tag, ".write_reg"},    32'(bus.write_reg_mem),    32'(m_wreg));
        if (with_data) begin
            chk({tag, ".write_data"},    bus.write_data_mem,    m_wd);
            chk({tag, ".branch_target"}, bus.branch_target_mem, m_tgt);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (m_rw && m_wreg != 0 && m_wreg == r) return m_res;
        if (bus.reg_write_wb && bus.write_reg_wb != 0 && bus.write_reg_wb == r) return bus.write_data_wb;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_NOR: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_ex(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc4, input logic rw,
                          input logic rdst, input logic asrc, input logic br, input logic [2:0] memc);
        bus.alu_op_ex = op; bus.rs_ex = rs; bus.rt_ex = rt; bus.rd_ex = rd;
        bus.read_data1_ex = d1; bus.read_data2_ex = d2;
        bus.sign_ext_imm_ex = imm; bus.pc_plus_4_ex = pc4;
        bus.reg_write_ex = rw; bus.reg_dst_ex = rdst; bus.alu_src_ex = asrc; bus.branch_ex = br;
        {bus.mem_to_reg_ex, bus.mem_read_ex, bus.mem_write_ex} = memc;
    endtask

    task automatic set_wb(input logic rw, input logic [4:0] r, input logic [31:0] d);
        bus.reg_write_wb = rw; bus.write_reg_wb = r; bus.write_data_wb = d;
    endtask

    // MUL: 33 stall cycles of bubbles, then product lands; WB source is scrambled meanwhile.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] wr);
        logic [31:0] prod;
        logic        rw, mtr, mr, mw;
        int          hi;
        bit          ended;
        prod = a * b;
        rw = bus.reg_write_ex; mtr = bus.mem_to_reg_ex; mr = bus.mem_read_ex; mw = bus.mem_write_ex;
        chk("mul_stall_start", 32'(bus.stall_ex), 32'd1);
        hi = bus.stall_ex ? 1 : 0;
        ended = !bus.stall_ex;
        model_clear();
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            cmp_mem("mul_bubble", 1'b1);
            if (bus.stall_ex && !ended) hi++;
            else ended = 1'b1;
            set_wb(1'($urandom), bus.rs_ex, $urandom);
        end
        chk("mul_stall_len", 32'(hi), 32'd33);
        chk("mul_stall_done", 32'(bus.stall_ex), 32'd0);
        @(posedge clk); #1;
        m_rw = rw; m_mtr = mtr; m_mr = mr; m_mw = mw;
        m_res = prod; m_wreg = wr; m_bt = 1'b0;
        cmp_mem("mul_result", 1'b0);
    endtask

    task automatic step();
        logic [31:0] fa, fb;
        logic [4:0]  wr;
        logic        sq;
        #1;
        fa = ref_fwd(bus.rs_ex, bus.read_data1_ex);
        fb = ref_fwd(bus.rt_ex, bus.read_data2_ex);
        wr = bus.reg_dst_ex ? bus.rd_ex : bus.rt_ex;
        sq = m_bt;
        if (bus.alu_op_ex == ALU_MUL && !sq) begin
            run_mul(fa, fb, wr);
            return;
        end
        chk("stall_idle", 32'(bus.stall_ex), 32'd0);
        @(posedge clk); #1;
        if (sq) begin
            model_clear();
        end else begin
            m_rw = bus.reg_write_ex; m_mtr = bus.mem_to_reg_ex;
            m_mr = bus.mem_read_ex;  m_mw = bus.mem_write_ex;
            m_res  = ref_alu(bus.alu_op_ex, fa, bus.alu_src_ex ? bus.sign_ext_imm_ex : fb);
            m_wd   = fb;
            m_wreg = wr;
            m_bt   = bus.branch_ex && (fa == fb);
            m_tgt  = bus.pc_plus_4_ex + bus.sign_ext_imm_ex * 4;
        end
        cmp_mem(sq ? "squash" : "alu", 1'b1);
    endtask

    initial begin
        logic [3:0] ops [8];
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, 4'b0011};

        reset = 1'b1;
        set_ex(ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        set_wb(0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(bus.stall_ex), 32'd0);
        cmp_mem("reset", 1'b1);
        @(negedge clk) reset = 1'b0;

        // Forwarding priority
        set_ex(ALU_ADD, 1, 2, 5, 32'h10, 32'h1, 0, 0, 1, 1, 0, 0, 3'b000); step();
        set_wb(1, 5, 32'h22);
        set_ex(ALU_ADD, 5, 6, 7, 32'hdead, 32'h1, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("fwd_mem_prio", bus.alu_result_mem, 32'h12);
        set_wb(0, 0, 0);
        set_ex(ALU_ADD, 1, 2, 0, 32'h3, 32'h4, 0, 0, 1, 1, 0, 0, 3'b000); step();
        set_wb(1, 5, 32'h22);
        set_ex(ALU_ADD, 5, 6, 8, 32'hbeef, 32'h1, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("fwd_wb_when_mem_r0", bus.alu_result_mem, 32'h23);
        set_wb(0, 0, 0);

        // ALU ops
        set_ex(ALU_SUB, 11, 12, 13, 32'd3, 32'd5, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("sub_neg", bus.alu_result_mem, 32'hFFFFFFFE);
        set_ex(ALU_SLT, 14, 15, 16, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("slt_signed", bus.alu_result_mem, 32'd1);
        set_ex(ALU_NOR, 17, 18, 19, 32'd0, 32'd0, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("nor_zero", bus.alu_result_mem, 32'hFFFFFFFF);
        set_ex(ALU_ADD, 20, 21, 22, 32'd8, 32'd99, 32'hFFFFFFFC, 0, 1, 0, 1, 0, 3'b000); step();
        chk("add_imm", bus.alu_result_mem, 32'd4);

        // Branch then squash
        set_ex(ALU_SUB, 23, 24, 0, 32'd7, 32'd7, 32'd3, 32'h100, 0, 0, 0, 1, 3'b000); step();
        chk("beq_taken", 32'(bus.branch_taken_mem), 32'd1);
        chk("beq_target", bus.branch_target_mem, 32'h10C);
        set_ex(ALU_ADD, 25, 26, 27, 32'd1, 32'd2, 0, 0, 1, 1, 0, 0, 3'b010); step();
        chk("squash_rw", 32'(bus.reg_write_mem), 32'd0);

        // Multiplies
        set_ex(ALU_MUL, 24, 25, 9, 32'd7, 32'd6, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("mul_7x6", bus.alu_result_mem, 32'd42);
        chk("mul_7x6_reg", 32'(bus.write_reg_mem), 32'd9);
        set_wb(0, 0, 0);
        set_ex(ALU_MUL, 26, 27, 10, 32'hFFFFFFFF, 32'd2, 0, 0, 1, 1, 0, 0, 3'b000); step();
        chk("mul_neg1x2", bus.alu_result_mem, 32'hFFFFFFFE);
        set_wb(0, 0, 0);

        // Reset during iteration 10
        set_ex(ALU_MUL, 28, 29, 11, 32'd5, 32'd9, 0, 0, 1, 1, 0, 0, 3'b000);
        #1;
        chk("rst_mul_start", 32'(bus.stall_ex), 32'd1);
        repeat (11) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_clear();
        chk("rst_mid_stall", 32'(bus.stall_ex), 32'd0);
        cmp_mem("rst_mid", 1'b1);
        set_ex(ALU_ADD, 1, 2, 12, 32'd2, 32'd3, 0, 0, 1, 1, 0, 0, 3'b000);
        @(negedge clk) reset = 1'b0;
        step();
        chk("post_rst_add", bus.alu_result_mem, 32'd5);
        set_ex(ALU_OR, 3, 4, 13, 32'h0F0, 32'h00F, 0, 0, 1, 1, 0, 0, 3'b000); step();

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] d1, d2;
            logic        br;
            op = ($urandom_range(0, 11) == 0) ? ALU_MUL : ops[$urandom_range(0, 7)];
            br = (op != ALU_MUL) && ($urandom_range(0, 3) == 0);
            d1 = $urandom;
            d2 = $urandom_range(0, 1) ? d1 : $urandom;
            set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            set_ex(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   d1, d2, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), br,
                   3'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
